// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, with a memory-wait FSM and stall counter.
// Define HAZARD_FORWARDING_EN to enable EX operand forwarding. Only load-use then stalls.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic [0:0] {StRun, StMemWait} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q;
    logic             match_rs1, match_rs2;
    logic             haz;
    logic             mem_wait;

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ALU results, so only a load in EX forces a bubble.
    assign match_rs1 = ex_reg_write & ex_mem_read & (ex_rd_addr == id_rs1_addr);
    assign match_rs2 = ex_reg_write & ex_mem_read & (ex_rd_addr == id_rs2_addr);

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!reset) begin
            if (mem_reg_write && (mem_rd_addr == ex_rs1_addr))     fwd_a_sel = 2'b01;
            else if (wb_reg_write && (wb_rd_addr == ex_rs1_addr)) fwd_a_sel = 2'b10;
            if (mem_reg_write && (mem_rd_addr == ex_rs2_addr))     fwd_b_sel = 2'b01;
            else if (wb_reg_write && (wb_rd_addr == ex_rs2_addr)) fwd_b_sel = 2'b10;
        end
    end
`else
    // Without forwarding, any in-flight writer in EX or MEM blocks ID; WB writes early enough.
    logic unused_fwd_inputs;

    assign match_rs1 = (ex_reg_write & (ex_rd_addr == id_rs1_addr)) |
                       (mem_reg_write & (mem_rd_addr == id_rs1_addr));
    assign match_rs2 = (ex_reg_write & (ex_rd_addr == id_rs2_addr)) |
                       (mem_reg_write & (mem_rd_addr == id_rs2_addr));
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign unused_fwd_inputs = ^{ex_rs1_addr, ex_rs2_addr, ex_mem_read, wb_rd_addr, wb_reg_write};
`endif

    assign haz = (id_rs1_used & match_rs1) | (id_rs2_used & match_rs2);

    // In MEM_WAIT the request is already outstanding; only the ready strobe releases it.
    assign mem_wait = (state_q == StRun) ? (mem_req & ~mem_ready) : ~mem_ready;

    always_comb begin
        state_d     = mem_wait ? StMemWait : StRun;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset || mem_wait) begin
            // hold everything frozen
        end else if (branch_taken) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (haz) begin
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARDING_EN when defined.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned CW = 4;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [4:0] WE_ALL = 5'b11111;
    localparam logic [4:0] WE_HAZ = 5'b00111;
    localparam logic [4:0] WE_NON = 5'b00000;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [AW-1:0] mem_rd_addr, wb_rd_addr;
    logic          id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write;
    logic          wb_reg_write, branch_taken, mem_req, mem_ready;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [4:0]    we;
        logic [1:0]    fl;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          sb_e;
    logic [CW-1:0] cnt_model = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push expected outputs for the cycle just driven; stall counter model advances after it.
    task automatic expect_cycle(input string tag, input logic [4:0] we, input logic [1:0] fl,
                                input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag = tag; e.we = we; e.fl = fl; e.fa = fa; e.fb = fb; e.cnt = cnt_model;
        sb_q.push_back(e);
        if (!reset && !we[4] && cnt_model != CNT_MAX) cnt_model = cnt_model + 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = '0;
        {mem_rd_addr, wb_rd_addr} = '0;
        {id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write} = '0;
        {wb_reg_write, branch_taken, mem_req, mem_ready} = '0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check_val({sb_e.tag, ".we"}, 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}),
                      32'(sb_e.we));
            check_val({sb_e.tag, ".flush"}, 32'({if_id_flush, id_ex_flush}), 32'(sb_e.fl));
            check_val({sb_e.tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(sb_e.fa));
            check_val({sb_e.tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(sb_e.fb));
            check_val({sb_e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(sb_e.cnt));
        end
    end

    initial begin
        clear_inputs();
        // Reset held with a live hazard and forwardable sources: outputs must stay quiet.
        ex_reg_write = 1; ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3; id_rs1_used = 1;
        mem_reg_write = 1; mem_rd_addr = 2; ex_rs2_addr = 2;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            expect_cycle("reset", WE_NON, 2'b00, 2'b00, 2'b00);
        end

        next_cycle(); reset = 0; clear_inputs();
        expect_cycle("idle", WE_ALL, 2'b00, 2'b00, 2'b00);

        next_cycle();
        ex_reg_write = 1; ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3; id_rs1_used = 1;
        expect_cycle("load_use", WE_HAZ, 2'b01, 2'b00, 2'b00);

        // Load now in WB; EX consumer of r3 picks it from MEM_WB.
        next_cycle(); clear_inputs();
        wb_reg_write = 1; wb_rd_addr = 3; ex_rs1_addr = 3;
        expect_cycle("after_load", WE_ALL, 2'b00, FWD ? 2'b10 : 2'b00, 2'b00);

        next_cycle(); clear_inputs();
        ex_reg_write = 1; ex_mem_read = 1; ex_rd_addr = 6; id_rs2_addr = 6; id_rs2_used = 0;
        expect_cycle("src_unused", WE_ALL, 2'b00, 2'b00, 2'b00);

        next_cycle(); clear_inputs();
        mem_reg_write = 1; mem_rd_addr = 2; wb_reg_write = 1; wb_rd_addr = 2; ex_rs2_addr = 2;
        expect_cycle("fwd_prio", WE_ALL, 2'b00, 2'b00, FWD ? 2'b01 : 2'b00);

        next_cycle(); mem_reg_write = 0;
        expect_cycle("fwd_wb", WE_ALL, 2'b00, 2'b00, FWD ? 2'b10 : 2'b00);

        next_cycle(); clear_inputs();
        mem_reg_write = 1; mem_rd_addr = 5; id_rs2_addr = 5; id_rs2_used = 1;
        expect_cycle("raw_mem", FWD ? WE_ALL : WE_HAZ, FWD ? 2'b00 : 2'b01, 2'b00, 2'b00);

        next_cycle(); clear_inputs();
        ex_reg_write = 1; ex_rd_addr = 4; id_rs1_addr = 4; id_rs1_used = 1;
        expect_cycle("raw_ex_alu", FWD ? WE_ALL : WE_HAZ, FWD ? 2'b00 : 2'b01, 2'b00, 2'b00);

        next_cycle(); clear_inputs();
        wb_reg_write = 1; wb_rd_addr = 1; id_rs1_addr = 1; id_rs1_used = 1;
        expect_cycle("raw_wb", WE_ALL, 2'b00, 2'b00, 2'b00);

        next_cycle(); clear_inputs(); mem_req = 1; mem_ready = 1;
        expect_cycle("mem_fast", WE_ALL, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < 3; i++) begin
            next_cycle(); mem_ready = 0;
            expect_cycle("mem_wait", WE_NON, 2'b00, 2'b00, 2'b00);
        end
        next_cycle(); mem_ready = 1;
        expect_cycle("mem_ready", WE_ALL, 2'b00, 2'b00, 2'b00);

        next_cycle(); clear_inputs(); mem_req = 1; branch_taken = 1;
        expect_cycle("br_in_wait", WE_NON, 2'b00, 2'b00, 2'b00);
        next_cycle(); mem_ready = 1;
        expect_cycle("br_on_ready", WE_ALL, 2'b11, 2'b00, 2'b00);

        next_cycle(); clear_inputs(); branch_taken = 1;
        ex_reg_write = 1; ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3; id_rs1_used = 1;
        expect_cycle("br_over_haz", WE_ALL, 2'b11, 2'b00, 2'b00);

        // Enter MEM_WAIT, then hit reset between clock edges.
        next_cycle(); clear_inputs(); mem_req = 1;
        mem_reg_write = 1; mem_rd_addr = 2; ex_rs2_addr = 2;
        expect_cycle("wait_enter", WE_NON, 2'b00, 2'b00, FWD ? 2'b01 : 2'b00);
        @(posedge clk); #3;
        reset = 1;
        #1;
        check_val("async_rst.we", 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 32'd0);
        check_val("async_rst.flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
        check_val("async_rst.fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        check_val("async_rst.stall_cycles", 32'(stall_cycles), 32'd0);
        cnt_model = '0;
        next_cycle(); reset = 0; clear_inputs();
        expect_cycle("post_reset", WE_ALL, 2'b00, 2'b00, 2'b00);

        // Long wait drives the narrow counter into saturation.
        next_cycle(); mem_req = 1;
        expect_cycle("sat_enter", WE_NON, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            expect_cycle("sat_wait", WE_NON, 2'b00, 2'b00, 2'b00);
        end
        next_cycle(); mem_ready = 1;
        expect_cycle("sat_ready", WE_ALL, 2'b00, 2'b00, 2'b00);
        next_cycle(); clear_inputs();
        expect_cycle("sat_hold", WE_ALL, 2'b00, 2'b00, 2'b00);

        @(posedge clk); @(negedge clk); #1;
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
